// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam logic [1:0] ILEN32_MARK = 2'b11;

    typedef struct packed {
        logic [DATA_BUS_WIDTH-1:0] pc;
        logic [DATA_BUS_WIDTH-1:0] word;
    } fetchEntry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: synchronous write, combinational head, async reset, flush.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign headData = mem[rdPtr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: PC sequencing, prefetch FIFO, redirect flush.
// Optional IFETCH_ILLEGAL_CHECK_EN adds the inst_illegal output.
module ifetch_unit #(
    parameter int DATA_BUS_WIDTH = ifetch_pkg::DATA_BUS_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_BUS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [DATA_BUS_WIDTH-1:0] imem_addr,
    output logic                      imem_wr,
    input  logic [DATA_BUS_WIDTH-1:0] imem_rdata,
    input  logic                      redirect_valid,
    input  logic [DATA_BUS_WIDTH-1:0] redirect_pc,
`ifdef IFETCH_ILLEGAL_CHECK_EN
    output logic                      inst_illegal,
`endif
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [DATA_BUS_WIDTH-1:0] inst_data,
    output logic [DATA_BUS_WIDTH-1:0] inst_pc
);

    import ifetch_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int EW    = 2*DATA_BUS_WIDTH;
    localparam logic [DATA_BUS_WIDTH-1:0] ALIGN_MASK = ~(DATA_BUS_WIDTH'(3));

    logic [DATA_BUS_WIDTH-1:0] pc;
    logic [EW-1:0]             headEntry;
    logic [CNT_W-1:0]          fifoCount;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic                      pop;
    logic                      push;

    assign inst_valid = (fifoCount != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = !redirect_valid & (!fifoFull | pop);

    // Redirect flushes the FIFO; a coincident pop is dropped with it.
    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop & !redirect_valid),
        .wrData   ({pc, imem_rdata}),
        .headData (headEntry),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (push) begin
            pc <= pc + DATA_BUS_WIDTH'(4);
        end
    end

    assign imem_addr = pc >> 2;
    assign imem_wr   = 1'b0;
    assign inst_pc   = fifoEmpty ? '0 : headEntry[EW-1 -: DATA_BUS_WIDTH];
    assign inst_data = fifoEmpty ? '0 : headEntry[DATA_BUS_WIDTH-1:0];

`ifdef IFETCH_ILLEGAL_CHECK_EN
    assign inst_illegal = inst_valid & (inst_data[1:0] != ILEN32_MARK);
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected {pc, word} stream per fetch target.
module tb_ifetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } expEntry_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_wr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IFETCH_ILLEGAL_CHECK_EN
    logic        inst_illegal;
`endif

    logic        override0;
    expEntry_t   expQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          delivered  = 0;
    int          sinceRedir = 0;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_wr        (imem_wr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFETCH_ILLEGAL_CHECK_EN
        .inst_illegal   (inst_illegal),
`endif
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: imem[k] = 0x13 | (k << 20), optional override at k = 0.
    assign imem_rdata = (override0 && imem_addr == 32'd0) ? 32'h0000_0001
                                                          : (32'h0000_0013 | (imem_addr << 20));

    function automatic logic [31:0] memWord(input logic [31:0] bytePc);
        logic [31:0] k;
        k = bytePc >> 2;
        if (override0 && k == 32'd0) return 32'h0000_0001;
        return 32'h0000_0013 | (k << 20);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // After a reset or redirect the only legal delivery order is target, target+4, ...
    task automatic restartStream(input logic [31:0] target);
        logic [31:0] p;
        expEntry_t e;
        expQ.delete();
        p = target & 32'hFFFF_FFFC;
        for (int i = 0; i < 300; i++) begin
            e.pc   = p;
            e.data = memWord(p);
            expQ.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        expEntry_t e;
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            if (expQ.size() == 0) begin
                check("unexpected_delivery", inst_pc, 32'hDEAD_BEEF);
            end else begin
                e = expQ.pop_front();
                check("deliver_pc", inst_pc, e.pc);
                check("deliver_data", inst_data, e.data);
                delivered++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        override0 = 1'b0;

        #2;
        check("reset_imem_addr", imem_addr, 32'd0);
        check("reset_imem_wr", {31'd0, imem_wr}, 32'd0);
        check("reset_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_data", inst_data, 32'd0);
        check("reset_pc", inst_pc, 32'd0);

        // Streaming after reset release
        tick(); tick();
        restartStream(32'd0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream_valid", {31'd0, inst_valid}, 32'd1);
            check("stream_pc", inst_pc, 32'(4*i));
            check("stream_data", inst_data, 32'h0000_0013 | (32'(i) << 20));
        end

        // Back-pressure from a fresh reset
        tick();
        reset = 1'b1;
        inst_ready = 1'b0;
        tick();
        restartStream(32'd0);
        reset = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("bp_count", 32'(dut.fifoCount), 32'd4);
        check("bp_imem_addr", imem_addr, 32'd4);
        check("bp_head_pc", inst_pc, 32'd0);
        check("bp_valid", {31'd0, inst_valid}, 32'd1);
        tick();
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_release_valid", {31'd0, inst_valid}, 32'd1);
            check("bp_release_pc", inst_pc, 32'(4*i));
        end

        // Redirect while full
        tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("full_before_redirect", 32'(dut.fifoCount), 32'd4);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        restartStream(32'h0000_0103);
        tick();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        check("redir_bubble_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("redir_target_pc", inst_pc, 32'h0000_0100);
        check("redir_target_data", inst_data, 32'h0400_0013);

        // Redirect coinciding with a pop
        tick();
        @(negedge clk);
        check("pop_redir_valid_before", {31'd0, inst_valid}, 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        restartStream(32'h0000_0200);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("pop_redir_count", 32'(dut.fifoCount), 32'd0);
        check("pop_redir_valid", {31'd0, inst_valid}, 32'd0);

        // Asynchronous reset between edges
        tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_valid", {31'd0, inst_valid}, 32'd0);
        check("async_reset_addr", imem_addr, 32'd0);
        check("async_reset_pc", inst_pc, 32'd0);
        tick(); tick();
        restartStream(32'd0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("after_reset_valid", {31'd0, inst_valid}, 32'd1);
        check("after_reset_pc", inst_pc, 32'd0);

        // PC wrap at the top of the address space
        tick();
`ifdef IFETCH_ILLEGAL_CHECK_EN
        override0 = 1'b1;
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        restartStream(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_bubble_valid", {31'd0, inst_valid}, 32'd0);
`ifdef IFETCH_ILLEGAL_CHECK_EN
        check("wrap_illegal_empty", {31'd0, inst_illegal}, 32'd0);
`endif
        @(negedge clk);
        check("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_top_data", inst_data, 32'hFFF0_0013);
`ifdef IFETCH_ILLEGAL_CHECK_EN
        check("wrap_top_illegal", {31'd0, inst_illegal}, 32'd0);
`endif
        @(negedge clk);
        check("wrap_zero_pc", inst_pc, 32'd0);
`ifdef IFETCH_ILLEGAL_CHECK_EN
        check("wrap_zero_data", inst_data, 32'h0000_0001);
        check("wrap_zero_illegal", {31'd0, inst_illegal}, 32'd1);
`else
        check("wrap_zero_data", inst_data, 32'h0000_0013);
`endif
        tick();
        override0 = 1'b0;

        // Randomized ready and redirect traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            inst_ready = ($urandom_range(0, 3) != 0);
            if (sinceRedir > 200 || $urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
                restartStream(redirect_pc);
                sinceRedir = 0;
            end else begin
                redirect_valid = 1'b0;
                sinceRedir++;
            end
        end
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        check("random_delivered_enough", {31'd0, (delivered >= 500)}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
